// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: fetch/decode/indirect/execute FSM over a
// single-port memory with ready handshake, carry flag and HALT.
module acc_cpu_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [DATA_W-1:0] ac_o,
  output logic              carry_o
);

  localparam int unsigned OP_W = 3;
  localparam logic [OP_W-1:0] OP_ADD    = 3'b000;
  localparam logic [OP_W-1:0] OP_ASHL   = 3'b001;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV2   = 3'b011;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'b100;
  localparam logic [OP_W-1:0] OP_STORE  = 3'b101;
  localparam logic [OP_W-1:0] OP_COMP2S = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT   = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_INDIR  = 3'd2,
    S_OPRD   = 3'd3,
    S_EXEC   = 3'd4,
    S_STORE  = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] dr_q, dr_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic              c_q, c_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              halted_q, halted_d;

  logic [OP_W-1:0]   op;
  logic              ind;
  logic [DATA_W:0]   sum;
  logic              unused_ir;

  assign op        = ir_q[DATA_W-2 -: OP_W];
  assign ind       = ir_q[DATA_W-1];
  assign sum       = {1'b0, ac_q} + {1'b0, dr_q};
  assign unused_ir = ^ir_q;

  // State and datapath registers; bus outputs are registered from next state
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ar_q     <= '0;
      ir_q     <= '0;
      dr_q     <= '0;
      ac_q     <= '0;
      c_q      <= 1'b0;
      rd_q     <= 1'b1;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ar_q     <= ar_d;
      ir_q     <= ir_d;
      dr_q     <= dr_d;
      ac_q     <= ac_d;
      c_q      <= c_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      halted_q <= halted_d;
    end
  end

  // Next-state, datapath update and Moore bus decode of the next state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ar_d    = ar_q;
    ir_d    = ir_q;
    dr_d    = dr_q;
    ac_d    = ac_q;
    c_d     = c_q;

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ar_d = ir_q[ADDR_W-1:0];
        if (op == OP_HALT)       state_d = S_HALT;
        else if (ind)            state_d = S_INDIR;
        else if (op == OP_STORE) state_d = S_STORE;
        else                     state_d = S_OPRD;
      end
      S_INDIR: begin
        if (mem_ready) begin
          ar_d    = mem_rdata[ADDR_W-1:0];
          state_d = (op == OP_STORE) ? S_STORE : S_OPRD;
        end
      end
      S_OPRD: begin
        if (mem_ready) begin
          dr_d    = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op)
          OP_ADD: begin
            ac_d = sum[DATA_W-1:0];
            c_d  = sum[DATA_W];
          end
          OP_ASHL: begin
            ac_d = {dr_q[DATA_W-2:0], 1'b0};
            c_d  = dr_q[DATA_W-1];
          end
          OP_XNOR:   ac_d = ~(ac_q ^ dr_q);
          OP_DIV2:   ac_d = {dr_q[DATA_W-1], dr_q[DATA_W-1:1]};
          OP_LOAD:   ac_d = dr_q;
          OP_COMP2S: ac_d = ~dr_q + DATA_W'(1);
          default:   ac_d = ac_q;
        endcase
        state_d = S_FETCH;
      end
      S_STORE: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    rd_d     = (state_d == S_FETCH) || (state_d == S_INDIR) || (state_d == S_OPRD);
    wr_d     = (state_d == S_STORE);
    addr_d   = (state_d == S_FETCH) ? pc_d : ar_d;
    halted_d = (state_d == S_HALT);
  end

  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_wdata = ac_q;
  assign halted    = halted_q;
  assign ac_o      = ac_q;
  assign carry_o   = c_q;

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param: 8/4 core with wait-state memory model and
// a 16/8 core on a zero-wait memory.
module tb_acc_cpu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 8-bit data / 4-bit address instance
  logic       clr_n;
  logic [3:0] addr;
  logic       rd, wr, ready, halted, carry;
  logic [7:0] wdata, rdata, ac;
  logic [7:0] mem [16];
  int         wait_n = 0;
  int         wcnt   = 0;

  acc_cpu_param #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .clr_n(clr_n), .mem_addr(addr), .mem_rd(rd), .mem_wr(wr),
    .mem_wdata(wdata), .mem_rdata(rdata), .mem_ready(ready),
    .halted(halted), .ac_o(ac), .carry_o(carry)
  );

  assign ready = (wcnt >= wait_n);
  assign rdata = mem[addr];

  // 16-bit data / 8-bit address instance, ready tied high
  logic        clr16_n;
  logic [7:0]  addr16;
  logic        rd16, wr16, halted16, carry16;
  logic [15:0] wdata16, rdata16, ac16;
  logic [15:0] mem16 [256];

  acc_cpu_param #(.DATA_W(16), .ADDR_W(8)) dut16 (
    .clk(clk), .clr_n(clr16_n), .mem_addr(addr16), .mem_rd(rd16), .mem_wr(wr16),
    .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ready(1'b1),
    .halted(halted16), .ac_o(ac16), .carry_o(carry16)
  );

  assign rdata16 = mem16[addr16];

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t       log_q [$];
  int         unstable = 0;
  int         both     = 0;
  logic       prev_wait = 1'b0;
  logic [3:0] prev_addr;
  logic       prev_rd, prev_wr;
  logic [7:0] prev_wdata;

  // Memory responder: wait-state counter, completed-access log, stability watch
  always @(posedge clk) begin
    if (!clr_n) begin
      wcnt      <= 0;
      prev_wait <= 1'b0;
    end else begin
      if (rd && wr) both <= both + 1;
      if (prev_wait && (addr !== prev_addr || rd !== prev_rd || wr !== prev_wr ||
                        wdata !== prev_wdata))
        unstable <= unstable + 1;
      if (rd || wr) begin
        if (ready) begin
          wcnt      <= 0;
          prev_wait <= 1'b0;
          log_q.push_back(acc_t'({wr, addr, wr ? wdata : rdata}));
        end else begin
          wcnt      <= wcnt + 1;
          prev_wait <= 1'b1;
        end
      end else begin
        wcnt      <= 0;
        prev_wait <= 1'b0;
      end
      prev_addr  <= addr;
      prev_rd    <= rd;
      prev_wr    <= wr;
      prev_wdata <= wdata;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    tick(1);
    clr_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  int         base;
  int         n_wr;
  acc_t       e;
  logic [4:0] exp_acc [7];

  initial begin
    clr_n   = 1'b0;
    clr16_n = 1'b0;
    for (int i = 0; i < 256; i++) mem16[i] = 16'h0000;
    mem16[0] = 16'h4008; mem16[1] = 16'h0009; mem16[2] = 16'h7000;
    mem16[8] = 16'h7FFF; mem16[9] = 16'h8001;

    // Test 1: LOAD 8, ADD 9, HALT with zero wait states
    clear_mem();
    mem[0] = 8'h48; mem[1] = 8'h09; mem[2] = 8'h70; mem[8] = 8'h7F; mem[9] = 8'h81;
    wait_n = 0;
    tick(2);
    base = log_q.size();
    do_reset();
    check("rst_rd", rd, 1);
    check("rst_wr", wr, 0);
    check("rst_addr", addr, 0);
    check("rst_halted", halted, 0);
    check("rst_ac", ac, 0);
    check("rst_carry", carry, 0);
    tick(9);
    check("t1_not_halted_c10", halted, 0);
    tick(1);
    check("t1_halted_c11", halted, 1);
    check("t1_ac", ac, 8'h00);
    check("t1_carry", carry, 1);
    check("t1_no_req", {rd, wr}, 2'b00);
    check("t1_accesses", log_q.size() - base, 5);

    // Test 2: same program, two wait cycles on every request
    wait_n = 2;
    base   = log_q.size();
    do_reset();
    tick(19);
    check("t2_not_halted_c20", halted, 0);
    tick(1);
    check("t2_halted_c21", halted, 1);
    check("t2_ac", ac, 8'h00);
    check("t2_carry", carry, 1);
    check("t2_accesses", log_q.size() - base, 5);
    check("t2_stable", unstable, 0);

    // Test 3: LOAD I @3, STORE I @4, HALT with I bit set
    clear_mem();
    mem[0] = 8'hC3; mem[1] = 8'hD4; mem[2] = 8'hF0;
    mem[3] = 8'h0A; mem[4] = 8'h0B; mem[10] = 8'h55;
    wait_n = 0;
    base   = log_q.size();
    do_reset();
    tick(3);
    check("t3_oprd_addr", addr, 4'hA);
    check("t3_oprd_rd", rd, 1);
    tick(2);
    check("t3_ac", ac, 8'h55);
    tick(5);
    check("t3_not_halted_c11", halted, 0);
    tick(1);
    check("t3_halted", halted, 1);
    exp_acc = '{5'h00, 5'h03, 5'h0A, 5'h01, 5'h04, 5'h1B, 5'h02};
    check("t3_accesses", log_q.size() - base, 7);
    if (log_q.size() - base == 7) begin
      for (int i = 0; i < 7; i++) begin
        e = log_q[base + i];
        check($sformatf("t3_seq%0d", i), {e.wr, e.addr}, exp_acc[i]);
      end
      e = log_q[base + 5];
      check("t3_store_data", e.data, 8'h55);
    end

    // Test 4: LOAD, STORE, COMP2S, DIV2, ASHL, XNOR, HALT
    clear_mem();
    mem[0] = 8'h48; mem[1] = 8'h5E; mem[2] = 8'h69; mem[3] = 8'h3A;
    mem[4] = 8'h1B; mem[5] = 8'h2C; mem[6] = 8'h70;
    mem[8] = 8'h3C; mem[9] = 8'h80; mem[10] = 8'h90; mem[11] = 8'hC1; mem[12] = 8'h0F;
    base = log_q.size();
    do_reset();
    tick(6);
    check("t4_store_wr", {rd, wr}, 2'b01);
    check("t4_store_addr", addr, 4'hE);
    check("t4_store_wdata", wdata, 8'h3C);
    tick(5);
    check("t4_comp2s", ac, 8'h80);
    tick(4);
    check("t4_div2", ac, 8'hC8);
    check("t4_div2_carry", carry, 0);
    tick(4);
    check("t4_ashl", ac, 8'h82);
    check("t4_ashl_carry", carry, 1);
    tick(4);
    check("t4_xnor", ac, 8'h72);
    check("t4_xnor_carry", carry, 1);
    tick(2);
    check("t4_halted", halted, 1);
    n_wr = 0;
    for (int i = base; i < log_q.size(); i++) begin
      e = log_q[i];
      if (e.wr) n_wr++;
    end
    check("t4_one_write", n_wr, 1);

    // Test 5a: PC wraps from 0xF to 0x0
    for (int i = 0; i < 15; i++) mem[i] = 8'h4E;
    mem[15] = 8'h0E;
    do_reset();
    tick(60);
    check("t5_fetch_f", {rd, addr}, 5'h1F);
    tick(4);
    check("t5_wrap_ac", ac, 8'h9C);
    check("t5_wrap_carry", carry, 0);
    check("t5_wrap_fetch0", {rd, addr}, 5'h10);

    // Test 5b: reset during a waited operand read
    clear_mem();
    mem[0] = 8'h48; mem[1] = 8'h09; mem[2] = 8'h48; mem[8] = 8'h77; mem[9] = 8'hFF;
    wait_n = 3;
    do_reset();
    tick(20);
    check("t5b_ac", ac, 8'h76);
    check("t5b_carry", carry, 1);
    tick(6);
    check("t5b_oprd_wait", {rd, addr}, 5'h18);
    clr_n = 1'b0;
    tick(1);
    clr_n = 1'b1;
    check("t5b_rst_req", {rd, wr, addr}, 6'h20);
    check("t5b_rst_ac", ac, 8'h00);
    check("t5b_rst_carry", carry, 0);
    check("t5b_rst_halted", halted, 0);
    check("never_rd_and_wr", both, 0);

    // Test 6: 16-bit data, 8-bit address
    clr16_n = 1'b0;
    tick(1);
    clr16_n = 1'b1;
    check("t6_rst_req", {rd16, wr16, addr16}, 10'h200);
    tick(4);
    check("t6_load", ac16, 16'h7FFF);
    tick(6);
    check("t6_halted", halted16, 1);
    check("t6_ac", ac16, 16'h0000);
    check("t6_carry", carry16, 1);
    check("t6_wdata", {wr16, wdata16}, 17'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
